sysid_ext: RTL and testbench

Parametrised system-identification and housekeeping slave on the Avalon-MM control fabric. It returns the build-time system ID and timestamp, and adds a capability word, a byte-writable scratch register, and a prescaled free-running uptime counter with atomic 64-bit snapshot, enable/clear control and a sticky overflow flag. Host software uses it to confirm image identity, probe fabric liveness and measure elapsed time.

---
 rtl/sysid_ext.sv | 144 ++++++++++++++
 tb/tb_sysid_ext.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sysid_ext.sv
// System-identification and housekeeping slave: ID/timestamp/capability words,
// a byte-writable scratch register and a prescaled uptime counter with snapshot.
module sysid_ext #(
    parameter logic [31:0] SYSTEM_ID = 32'd1287393522,
    parameter logic [31:0] TIMESTAMP = 32'd1320971153,
    parameter logic [7:0]  VERSION   = 8'h02,
    parameter int          UPTIME_W  = 64,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    generate
        if (UPTIME_W < 33 || UPTIME_W > 64) begin : g_bad_uptime_w
            $error("sysid_ext: UPTIME_W must be within 33..64");
        end
        if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
            $error("sysid_ext: PRESCALE must be within 1..65535");
        end
    endgenerate

    localparam logic [2:0] A_ID      = 3'd0;
    localparam logic [2:0] A_TS      = 3'd1;
    localparam logic [2:0] A_CAP     = 3'd2;
    localparam logic [2:0] A_SCRATCH = 3'd3;
    localparam logic [2:0] A_UPLO    = 3'd4;
    localparam logic [2:0] A_UPHI    = 3'd5;
    localparam logic [2:0] A_CTRL    = 3'd6;

    localparam logic [7:0]          CAP_W    = 8'(UPTIME_W);
    localparam logic [15:0]         CAP_P    = 16'(PRESCALE);
    localparam logic [15:0]         PRE_LAST = 16'(PRESCALE - 1);
    localparam logic [UPTIME_W-1:0] CNT_ONE  = UPTIME_W'(1);

    logic [UPTIME_W-1:0] cnt;
    logic [UPTIME_W-1:0] cnt_nxt;
    logic [15:0]         pre;
    logic [15:0]         pre_nxt;
    logic                en;
    logic                ovf;
    logic [31:0]         scratch;
    logic [31:0]         scratch_nxt;
    logic [31:0]         shadow;
    logic [31:0]         hi_sample;
    logic [31:0]         rmux_p0;
    logic [31:0]         rdata_p1;
    logic                vld_p1;
    logic                ctrl_wr;
    logic                scratch_wr;
    logic                clr;
    logic                tick;
    logic                wrap;

    assign ctrl_wr    = write && (address == A_CTRL) && byteenable[0];
    assign scratch_wr = write && (address == A_SCRATCH);
    assign clr        = ctrl_wr && writedata[1];
    assign tick       = en && (pre == PRE_LAST);
    assign wrap       = tick && (&cnt);
    assign hi_sample  = 32'(cnt >> 32);

    // Clear has priority over a pending increment; EN=0 holds both counters.
    always_comb begin
        pre_nxt = pre;
        cnt_nxt = cnt;
        if (clr) begin
            pre_nxt = '0;
            cnt_nxt = '0;
        end else if (tick) begin
            pre_nxt = '0;
            cnt_nxt = cnt + CNT_ONE;
        end else if (en) begin
            pre_nxt = pre + 16'd1;
        end
    end

    always_comb begin
        scratch_nxt = scratch;
        for (int b = 0; b < 4; b++) begin
            if (scratch_wr && byteenable[b]) begin
                scratch_nxt[8*b +: 8] = writedata[8*b +: 8];
            end
        end
    end

    always_comb begin
        rmux_p0 = '0;
        case (address)
            A_ID:      rmux_p0 = SYSTEM_ID;
            A_TS:      rmux_p0 = TIMESTAMP;
            A_CAP:     rmux_p0 = {CAP_W, CAP_P, VERSION};
            A_SCRATCH: rmux_p0 = scratch;
            A_UPLO:    rmux_p0 = cnt[31:0];
            A_UPHI:    rmux_p0 = shadow;
            A_CTRL:    rmux_p0 = {29'd0, ovf, 1'b0, en};
            default:   rmux_p0 = '0;
        endcase
    end

    // Stage p0 -> p1: read data and valid registered together; the UPTIME_LO
    // read captures the upper counter bits from the same pre-increment sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            pre      <= '0;
            en       <= 1'b1;
            ovf      <= 1'b0;
            scratch  <= '0;
            shadow   <= '0;
            rdata_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            pre     <= pre_nxt;
            scratch <= scratch_nxt;
            vld_p1  <= read;
            if (read) begin
                rdata_p1 <= rmux_p0;
                if (address == A_UPLO) begin
                    shadow <= hi_sample;
                end
            end
            if (ctrl_wr) begin
                en <= writedata[0];
            end
            if (wrap && !clr) begin
                ovf <= 1'b1;
            end else if (ctrl_wr && writedata[2]) begin
                ovf <= 1'b0;
            end
        end
    end

    assign readdata      = rdata_p1;
    assign readdatavalid = vld_p1;

endmodule

// File: tb/tb_sysid_ext.sv
// Directed bench for sysid_ext: three instances (default, PRESCALE=4, UPTIME_W=33)
// share one bus; each step checks hand-computed read data.
module tb_sysid_ext;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] rdata0, rdata4, rdata33;
    logic        vld0, vld4, vld33;

    int n_cmp = 0;
    int n_bad = 0;

    sysid_ext dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .readdata(rdata0), .readdatavalid(vld0)
    );

    sysid_ext #(.PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .readdata(rdata4), .readdatavalid(vld4)
    );

    sysid_ext #(.UPTIME_W(33)) dut33 (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .readdata(rdata33), .readdatavalid(vld33)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        address = a; writedata = d; byteenable = be; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a);
        @(negedge clk);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0;
        address = '0; writedata = '0; byteenable = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rdata_before_read", rdata0, 32'd0);
        check("vld_idle", vld0, 1'b0);

        // Identification words
        bus_read(3'd0);
        check("id_vld", vld0, 1'b1);
        check("id", rdata0, 32'd1287393522);
        @(negedge clk);
        check("id_vld_one_cycle", vld0, 1'b0);
        check("id_hold", rdata0, 32'd1287393522);
        bus_read(3'd1);
        check("ts", rdata0, 32'd1320971153);
        bus_read(3'd2);
        check("cap_default", rdata0, 32'h4000_0102);
        check("cap_p4", rdata4, 32'h4000_0402);
        check("cap_w33", rdata33, 32'h2100_0102);
        check("cap_vld_w33", vld33, 1'b1);

        // Scratch with byte lanes, reserved word, read+write collision
        bus_write(3'd3, 32'hDEAD_BEEF, 4'hF);
        bus_read(3'd3);
        check("scratch_full", rdata0, 32'hDEAD_BEEF);
        bus_write(3'd3, 32'h0000_0000, 4'b0101);
        bus_read(3'd3);
        check("scratch_be0101", rdata0, 32'hDE00_BE00);
        bus_write(3'd7, 32'h1234_5678, 4'hF);
        bus_read(3'd7);
        check("reserved_reads_0", rdata0, 32'd0);
        @(negedge clk);
        address = 3'd3; read = 1'b1; write = 1'b1;
        writedata = 32'h1111_1111; byteenable = 4'hF;
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        check("rw_same_cycle_old", rdata0, 32'hDE00_BE00);
        bus_read(3'd3);
        check("rw_same_cycle_new", rdata0, 32'h1111_1111);

        // Uptime: CLR, then read sampled 40 edges later
        bus_write(3'd6, 32'h3, 4'h1);
        repeat (38) @(negedge clk);
        bus_read(3'd4);
        check("uptime_p4_40", rdata4, 32'd9);
        check("uptime_p1_40", rdata0, 32'd39);
        bus_write(3'd6, 32'h0, 4'h1);
        bus_read(3'd4);
        check("uptime_p4_frozen", rdata4, 32'd10);
        check("uptime_p1_frozen", rdata0, 32'd42);
        repeat (100) @(negedge clk);
        bus_read(3'd4);
        check("uptime_p4_frozen_100", rdata4, 32'd10);
        check("uptime_p1_frozen_100", rdata0, 32'd42);

        // Overflow on the 33-bit counter, preloaded while frozen
        @(negedge clk);
        force dut33.cnt = 33'h1_FFFF_FFFF;
        @(posedge clk);
        #1 release dut33.cnt;
        bus_write(3'd6, 32'h1, 4'h1);
        bus_read(3'd4);
        check("wrap_cnt_zero", rdata33, 32'd0);
        bus_read(3'd5);
        check("wrap_hi_zero", rdata33, 32'd0);
        bus_read(3'd6);
        check("ovf_set", rdata33, 32'h5);
        check("ovf_other_inst", rdata0, 32'h1);
        bus_write(3'd6, 32'h5, 4'h1);
        bus_read(3'd6);
        check("ovf_w1c", rdata33, 32'h1);

        // Wrap and W1C in the same cycle: set wins
        bus_write(3'd6, 32'h0, 4'h1);
        @(negedge clk);
        force dut33.cnt = 33'h1_FFFF_FFFF;
        @(posedge clk);
        #1 release dut33.cnt;
        bus_write(3'd6, 32'h1, 4'h1);
        address = 3'd6; writedata = 32'h5; byteenable = 4'h1; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        bus_read(3'd6);
        check("ovf_set_beats_w1c", rdata33, 32'h5);

        // CLR coinciding with the wrapping increment: clear wins, no OVF
        bus_write(3'd6, 32'h4, 4'h1);
        @(negedge clk);
        force dut33.cnt = 33'h1_FFFF_FFFF;
        @(posedge clk);
        #1 release dut33.cnt;
        bus_write(3'd6, 32'h1, 4'h1);
        address = 3'd6; writedata = 32'h3; byteenable = 4'h1; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        bus_read(3'd4);
        check("clr_beats_inc_cnt", rdata33, 32'd1);
        bus_read(3'd6);
        check("clr_beats_inc_ovf", rdata33, 32'h1);

        // Atomic snapshot on the 64-bit counter
        @(negedge clk);
        force dut.cnt = 64'h0000_0001_FFFF_FFFF;
        address = 3'd4; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        release dut.cnt;
        check("snap_lo", rdata0, 32'hFFFF_FFFF);
        repeat (5) @(negedge clk);
        bus_read(3'd5);
        check("snap_hi", rdata0, 32'h0000_0001);

        // Reset asserted between read and readdatavalid
        bus_write(3'd6, 32'h0, 4'h1);
        @(negedge clk);
        address = 3'd0; read = 1'b1;
        #2 reset = 1'b1;
        #1 check("async_rst_rdata", rdata0, 32'd0);
        @(negedge clk);
        read = 1'b0;
        check("rst_cancels_vld", vld0, 1'b0);
        check("rst_rdata", rdata0, 32'd0);
        reset = 1'b0;
        address = 3'd5; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        check("rst_shadow_vld", vld0, 1'b1);
        check("rst_shadow", rdata0, 32'd0);
        bus_read(3'd6);
        check("rst_ctrl", rdata0, 32'h1);
        bus_read(3'd3);
        check("rst_scratch", rdata0, 32'd0);
        bus_read(3'd4);
        check("rst_cnt_p1", rdata0, 32'd6);
        check("rst_cnt_p4", rdata4, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
